// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end (pc/issue to imem, in-order response FIFO to decode, redirect flush, debug halt/resume)
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-3:0] rst_addr,
  input  logic                  dbg_on_rst,
  input  logic                  dbg_halt,
  input  logic                  dbg_resume,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-3:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_insn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-3:0] out_addr,
  output logic [31:0]           out_insn
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc, rsp_pc;
  logic run, boot;
  logic [CW-1:0] inflight, drop, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [31:0] fifo_insn [DEPTH];
  logic [CW:0] credit;
  logic issue, rsp_ok, push, pop;
  assign credit = {1'b0, count} + {1'b0, inflight};
  assign issue = run && !redirect_en && credit < (CW+1)'(DEPTH);
  assign rsp_ok = imem_rsp_valid && inflight != '0;
  assign push = rsp_ok && drop == '0 && !redirect_en;
  assign pop = out_valid && out_ready;
  assign imem_req = issue;
  assign imem_addr = pc;
  assign out_valid = count != '0 && !redirect_en;
  assign out_addr = fifo_addr[rd_ptr];
  assign out_insn = fifo_insn[rd_ptr];
  always_ff @(posedge clk)
    if (rst) begin
      pc <= rst_addr;
      rsp_pc <= rst_addr;
      run <= 1'b0;
      boot <= 1'b1;
      inflight <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      boot <= 1'b0;
      run <= boot ? !dbg_on_rst : dbg_halt ? 1'b0 : dbg_resume ? 1'b1 : run;
      inflight <= inflight + CW'(issue) - CW'(rsp_ok);
      if (redirect_en) begin
        pc <= redirect_addr;
        rsp_pc <= redirect_addr;
        drop <= inflight - CW'(rsp_ok);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (issue) pc <= pc + AW'(1);
        if (rsp_ok && drop != '0) drop <= drop - CW'(1);
        if (push) rsp_pc <= rsp_pc + AW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr[wr_ptr] <= rsp_pc;
      fifo_insn[wr_ptr] <= imem_rsp_insn;
    end
  assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && inflight == '0));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;
  localparam int AW = 6;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, dbg_on_rst = 0, dbg_halt = 0, dbg_resume = 0;
  logic redirect_en = 0, imem_rsp_valid = 0, out_ready = 0;
  logic [AW-1:0] rst_addr = 0, redirect_addr = 0, imem_addr, out_addr;
  logic [31:0] imem_rsp_insn = 0, out_insn;
  logic imem_req, out_valid;

  fetch_queue #(.ADDR_WIDTH(AW + 2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rst_addr(rst_addr), .dbg_on_rst(dbg_on_rst),
    .dbg_halt(dbg_halt), .dbg_resume(dbg_resume), .redirect_en(redirect_en),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_insn(imem_rsp_insn),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_insn(out_insn)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [31:0] i;} ent_t;
  typedef struct {logic [AW-1:0] a; int due;} req_t;
  ent_t fifo[$];
  req_t mq[$];
  logic [AW-1:0] m_pc, m_rsp_pc;
  bit m_run, m_boot, m_valid;
  int m_infl, m_drop;
  int checks = 0, errors = 0, cyc = 0, lat = 1, jit = 0, last_due = 0;
  logic s_req, s_ov;
  logic [AW-1:0] s_addr, s_oaddr;

  function automatic logic [31:0] mem(logic [AW-1:0] a);
    return 32'h5A000000 ^ ({26'd0, a} * 32'h9E3779B1);
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit iss, e_ov, rv;
    logic [31:0] ri;
    int due;
    rv = 0;
    ri = $urandom;
    if (!rst && mq.size() != 0 && mq[0].due == cyc) begin
      rv = 1;
      ri = mem(mq[0].a);
      void'(mq.pop_front());
    end
    imem_rsp_valid = rv;
    imem_rsp_insn = ri;
    #4;
    s_req = imem_req;
    s_addr = imem_addr;
    s_ov = out_valid;
    s_oaddr = out_addr;
    if (m_valid) begin
      iss = m_run && !redirect_en && fifo.size() + m_infl < DEPTH;
      e_ov = fifo.size() != 0 && !redirect_en;
      chk("imem_req", imem_req, iss);
      if (iss) chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) begin
        chk("out_addr", out_addr, fifo[0].a);
        chk("out_insn", out_insn, fifo[0].i);
      end
      if (!rst) begin
        if (m_boot) m_run = !dbg_on_rst;
        else if (dbg_halt) m_run = 0;
        else if (dbg_resume) m_run = 1;
        m_boot = 0;
        if (redirect_en) begin
          m_pc = redirect_addr;
          m_rsp_pc = redirect_addr;
          fifo.delete();
          m_drop = m_infl - int'(rv);
          m_infl -= int'(rv);
        end else begin
          if (iss) begin
            due = cyc + lat + int'($urandom_range(0, jit));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{m_pc, due});
            m_pc++;
          end
          if (e_ov && out_ready) void'(fifo.pop_front());
          if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
              fifo.push_back('{m_rsp_pc, ri});
              m_rsp_pc++;
            end
          end
          m_infl += int'(iss) - int'(rv);
        end
      end
    end
    if (rst) begin
      m_pc = rst_addr;
      m_rsp_pc = rst_addr;
      m_run = 0;
      m_boot = 1;
      m_infl = 0;
      m_drop = 0;
      fifo.delete();
      mq.delete();
      last_due = 0;
      m_valid = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(logic [AW-1:0] ra, bit dor, int l, int j);
    rst = 1;
    rst_addr = ra;
    dbg_on_rst = dor;
    lat = l;
    jit = j;
    dbg_halt = 0;
    dbg_resume = 0;
    redirect_en = 0;
    repeat (3) step();
    chk("reset imem_req", s_req, 0);
    chk("reset out_valid", s_ov, 0);
    rst = 0;
  endtask

  initial begin
    int n;
    bit found;
    @(posedge clk);
    #1;
    do_reset(6'h10, 0, 1, 0);
    out_ready = 1;
    step(); chk("p1 c0 req", s_req, 0);
    step(); chk("p1 c1 req", s_req, 1); chk("p1 c1 addr", s_addr, 6'h10);
    step(); chk("p1 c2 addr", s_addr, 6'h11);
    step(); chk("p1 c3 ov", s_ov, 1); chk("p1 c3 oaddr", s_oaddr, 6'h10);
    step(); chk("p1 c4 ov", s_ov, 1); chk("p1 c4 oaddr", s_oaddr, 6'h11);
    repeat (8) step();

    do_reset(6'h20, 0, 3, 0);
    out_ready = 0;
    n = 0;
    repeat (20) begin step(); n += int'(s_req); end
    chk("p2 requests", n, 4);
    chk("p2 req idle", s_req, 0);
    chk("p2 model count", fifo.size(), 4);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("p2 drain ov", s_ov, 1);
      chk("p2 drain addr", s_oaddr, 6'h20 + k);
    end
    repeat (10) step();

    do_reset(6'h30, 0, 4, 0);
    out_ready = 1;
    repeat (4) step();
    chk("p3 model inflight", m_infl, 3);
    redirect_en = 1;
    redirect_addr = 6'h20;
    step();
    redirect_en = 0;
    chk("p3 model drop", m_drop, 3);
    step(); chk("p3 new req", s_req, 1); chk("p3 new addr", s_addr, 6'h20);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_ov) begin found = 1; chk("p3 first out", s_oaddr, 6'h20); end
    end
    chk("p3 out seen", found, 1);

    do_reset(6'h00, 0, 1, 0);
    out_ready = 1;
    repeat (6) step();
    chk("p4 model count", fifo.size(), 1);
    redirect_en = 1;
    redirect_addr = 6'h15;
    step(); chk("p4 ov at r", s_ov, 0);
    redirect_en = 0;
    step(); chk("p4 ov at r+1", s_ov, 0); chk("p4 req r+1", s_req, 1); chk("p4 addr r+1", s_addr, 6'h15);
    step(); chk("p4 ov at r+2", s_ov, 0);
    step(); chk("p4 ov at r+3", s_ov, 1); chk("p4 oaddr r+3", s_oaddr, 6'h15);
    repeat (4) step();

    do_reset(6'h08, 1, 2, 0);
    out_ready = 1;
    n = 0;
    repeat (8) begin step(); n += int'(s_req); end
    chk("p5 halted reqs", n, 0);
    dbg_halt = 1;
    dbg_resume = 1;
    step();
    dbg_halt = 0;
    dbg_resume = 0;
    n = 0;
    repeat (4) begin step(); n += int'(s_req); end
    chk("p5 halt+resume reqs", n, 0);
    dbg_resume = 1;
    step(); chk("p5 req at s", s_req, 0);
    dbg_resume = 0;
    step(); chk("p5 req at s+1", s_req, 1); chk("p5 first addr", s_addr, 6'h08);
    repeat (3) step();
    dbg_halt = 1;
    step();
    dbg_halt = 0;
    step(); chk("p5 req after halt", s_req, 0);
    repeat (6) step();

    do_reset(6'h3E, 0, 2, 0);
    out_ready = 1;
    repeat (3) step();
    step(); chk("p6 wrap addr", s_addr, 6'h00);
    step(); chk("p6 out 3E", s_oaddr, 6'h3E);
    step(); chk("p6 out 3F", s_oaddr, 6'h3F);
    step(); chk("p6 out 00", s_oaddr, 6'h00); chk("p6 ov", s_ov, 1);

    do_reset(6'($urandom), 0, 3, 2);
    repeat (4000) begin
      if ($urandom_range(0, 299) == 0)
        do_reset(6'($urandom), $urandom_range(0, 3) == 0, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
      dbg_halt = $urandom_range(0, 39) == 0;
      dbg_resume = $urandom_range(0, 7) == 0;
      redirect_en = $urandom_range(0, 29) == 0;
      redirect_addr = 6'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
